// File: rtl/pbit_sweep_scheduler.sv
// Purpose: sequential-Gibbs sweep scheduler sharing one P-bit among N_PBITS spins; optional clamp via PBIT_SCHED_CLAMP_EN.
// Latency: per p-bit, one FETCH plus the read latency per weight/bias, then one EVAL cycle; done follows the final EVAL.
// Backpressure: at most one weight read outstanding; the scheduler stalls in WAIT until w_valid arrives.
module pbit_sweep_scheduler #(
  parameter int N_PBITS = 8,
  parameter int ACC_W   = 14   // must cover 8 + ceil(log2(N_PBITS+1)) bits so sums never wrap
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [15:0]         num_sweeps,
  output logic                busy,
  output logic                done,
  output logic                w_req,
  output logic [11:0]         w_addr,
  input  logic                w_valid,
  input  logic signed [7:0]   w_data,
  output logic signed [7:0]   pb_I,
  output logic                pb_enable,
  input  logic                pb_m,
`ifdef PBIT_SCHED_CLAMP_EN
  input  logic [N_PBITS-1:0]  clamp_mask,
  input  logic [N_PBITS-1:0]  clamp_val,
`endif
  output logic [N_PBITS-1:0]  state,
  output logic [15:0]         sweep_cnt
);

  localparam int IW = $clog2(N_PBITS);
  localparam int JW = $clog2(N_PBITS + 1);
  localparam logic [JW-1:0]          J_BIAS = JW'(N_PBITS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EVAL, DONE} st_t;

  st_t                      st_q, st_d;
  logic [IW-1:0]            i_q;
  logic [JW-1:0]            j_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [N_PBITS-1:0]       m_q;
  logic [15:0]              sweep_q;
  logic [15:0]              nsw_q;
  logic [N_PBITS-1:0]       skip_q;

  logic [N_PBITS-1:0]       skip_start;
  logic [N_PBITS-1:0]       clamp_force;
  logic                     first_start_vld;
  logic [IW-1:0]            first_start_idx;
  logic [IW-1:0]            first_run_idx;
  logic                     next_vld;
  logic [IW-1:0]            next_idx;
  logic [JW-1:0]            j_inc;
  logic [JW-1:0]            j_next;
  logic signed [ACC_W-1:0]  w_ext;
  logic [N_PBITS:0]         m_ext;
  logic signed [ACC_W-1:0]  acc_add;
  logic signed [7:0]        pb_sat;
  logic                     last_sweep;

  // Clamped p-bits are never fetched or evaluated; their spin is forced once at run start.
`ifdef PBIT_SCHED_CLAMP_EN
  assign skip_start  = clamp_mask;
  assign clamp_force = clamp_val & clamp_mask;
`else
  assign skip_start  = '0;
  assign clamp_force = '0;
`endif

  // First weight index for a p-bit: the self-weight J_ii is never fetched.
  function automatic logic [JW-1:0] first_j(input logic [IW-1:0] ii);
    return (ii == '0) ? JW'(1) : '0;
  endfunction

  // Find the first evaluated p-bit for a new run, the first for the next sweep, and the successor of i.
  always_comb begin
    first_start_vld = 1'b0;
    first_start_idx = '0;
    first_run_idx   = '0;
    next_vld        = 1'b0;
    next_idx        = '0;
    for (int k = N_PBITS - 1; k >= 0; k--) begin
      if (!skip_start[k]) begin
        first_start_vld = 1'b1;
        first_start_idx = IW'(k);
      end
      if (!skip_q[k]) begin
        first_run_idx = IW'(k);
      end
      if (!skip_q[k] && (k > int'(i_q))) begin
        next_vld = 1'b1;
        next_idx = IW'(k);
      end
    end
  end

  // Next weight column, stepping over the diagonal; j never passes the bias slot since i < N_PBITS.
  assign j_inc  = j_q + JW'(1);
  assign j_next = (j_inc == JW'(i_q)) ? (j_q + JW'(2)) : j_inc;

  // Signed contribution: bias adds as-is, a weight adds for spin 1 and subtracts for spin 0.
  assign w_ext   = ACC_W'(w_data);
  assign m_ext   = {1'b0, m_q};
  assign acc_add = ((j_q == J_BIAS) || m_ext[j_q]) ? (acc_q + w_ext) : (acc_q - w_ext);

  assign last_sweep = ((sweep_q + 16'd1) == nsw_q);
  assign w_addr     = 12'(i_q) * 12'(N_PBITS + 1) + 12'(j_q);
  assign state      = m_q;
  assign sweep_cnt  = sweep_q;

  // Clip the accumulator into the P-bit's 8-bit signed input range.
  always_comb begin
    if (acc_q > SAT_HI) begin
      pb_sat = 8'sh7F;
    end else if (acc_q < SAT_LO) begin
      pb_sat = 8'sh80;
    end else begin
      pb_sat = acc_q[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    st_d      = st_q;
    busy      = 1'b0;
    done      = 1'b0;
    w_req     = 1'b0;
    pb_enable = 1'b0;
    pb_I      = '0;
    case (st_q)
      IDLE: begin
        // A run with nothing to evaluate (zero sweeps or every p-bit clamped) finishes immediately.
        if (start) begin
          st_d = ((num_sweeps == 16'd0) || !first_start_vld) ? DONE : FETCH;
        end
      end
      FETCH: begin
        busy  = 1'b1;
        w_req = 1'b1;
        st_d  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (w_valid) begin
          st_d = (j_q == J_BIAS) ? EVAL : FETCH;
        end
      end
      EVAL: begin
        busy      = 1'b1;
        pb_enable = 1'b1;
        pb_I      = pb_sat;
        st_d      = (!next_vld && last_sweep) ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Run bookkeeping: accumulation, index stepping, spin write-back and sweep counting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      sweep_q <= '0;
      nsw_q   <= '0;
      skip_q  <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (start) begin
            nsw_q   <= num_sweeps;
            sweep_q <= '0;
            skip_q  <= skip_start;
            m_q     <= (m_q & ~skip_start) | clamp_force;
            i_q     <= first_start_idx;
            j_q     <= first_j(first_start_idx);
            acc_q   <= '0;
          end
        end
        WAIT: begin
          if (w_valid) begin
            acc_q <= acc_add;
            if (j_q != J_BIAS) begin
              j_q <= j_next;
            end
          end
        end
        EVAL: begin
          // The new spin is visible to every later accumulation in this sweep.
          m_q[i_q] <= pb_m;
          acc_q    <= '0;
          if (next_vld) begin
            i_q <= next_idx;
            j_q <= first_j(next_idx);
          end else begin
            i_q     <= first_run_idx;
            j_q     <= first_j(first_run_idx);
            sweep_q <= sweep_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
`timescale 1ns/1ps
module tb_pbit_sweep_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic w_valid;
  logic signed [7:0] w_data;

  logic start4, busy4, done4, w_req4, pb_en4, pb_m4;
  logic [15:0] nsw4, scnt4;
  logic [11:0] w_addr4;
  logic signed [7:0] pb_I4;
  logic [3:0] state4;

  logic start8, busy8, done8, w_req8, pb_en8, pb_m8;
  logic [15:0] nsw8, scnt8;
  logic [11:0] w_addr8;
  logic signed [7:0] pb_I8;
  logic [7:0] state8;

`ifdef PBIT_SCHED_CLAMP_EN
  logic [3:0] clamp_mask4, clamp_val4;
  logic [7:0] clamp_mask8, clamp_val8;
`endif

  assign pb_m4 = (pb_I4 > 8'sd0);
  assign pb_m8 = (pb_I8 > 8'sd0);

  pbit_sweep_scheduler #(.N_PBITS(4), .ACC_W(14)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .num_sweeps(nsw4),
    .busy(busy4), .done(done4), .w_req(w_req4), .w_addr(w_addr4),
    .w_valid(w_valid), .w_data(w_data), .pb_I(pb_I4), .pb_enable(pb_en4), .pb_m(pb_m4),
`ifdef PBIT_SCHED_CLAMP_EN
    .clamp_mask(clamp_mask4), .clamp_val(clamp_val4),
`endif
    .state(state4), .sweep_cnt(scnt4)
  );

  pbit_sweep_scheduler #(.N_PBITS(8), .ACC_W(14)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .num_sweeps(nsw8),
    .busy(busy8), .done(done8), .w_req(w_req8), .w_addr(w_addr8),
    .w_valid(w_valid), .w_data(w_data), .pb_I(pb_I8), .pb_enable(pb_en8), .pb_m(pb_m8),
`ifdef PBIT_SCHED_CLAMP_EN
    .clamp_mask(clamp_mask8), .clamp_val(clamp_val8),
`endif
    .state(state8), .sweep_cnt(scnt8)
  );

  int checks = 0;
  int failures = 0;

  // Weight pattern: 0 = J 0 / bias +100, 1 = all +127, 2 = all -128.
  int mode = 0;
  int lat_fixed = 1;   // 0 selects the rotating 1..7 latency
  int lat_seq = 0;

  // Expected N=4 fetch order for one sweep (diagonal skipped, bias last).
  int exp_addr4 [16] = '{1, 2, 3, 4, 5, 7, 8, 9, 10, 11, 13, 14, 15, 16, 17, 19};
  int exp_neg8 [8] = '{-128, -128, -128, -128, 0, 127, 127, 127};

  function automatic logic signed [7:0] weight(input int m, input int addr, input int n);
    int j;
    j = addr % (n + 1);
    case (m)
      0:       return (j == n) ? 8'sd100 : 8'sd0;
      1:       return 8'sd127;
      default: return 8'sh80;
    endcase
  endfunction

  // Weight memory: answers one request at a time after the selected latency.
  initial begin
    int a, n, l;
    w_valid = 1'b0;
    w_data  = '0;
    forever begin
      if (w_req4 === 1'b1 || w_req8 === 1'b1) begin
        if (w_req4 === 1'b1) begin a = int'(w_addr4); n = 4; end
        else begin a = int'(w_addr8); n = 8; end
        if (lat_fixed > 0) l = lat_fixed;
        else begin l = 1 + (lat_seq % 7); lat_seq++; end
        repeat (l) @(posedge clk);
        #1 w_valid = 1'b1; w_data = weight(mode, a, n);
        @(posedge clk);
        #1 w_valid = 1'b0; w_data = '0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  int wreq4_n, pben4_n, done4_n, busy4_n, wreq8_n, pben8_n, done8_n;
  int addr_i0_n, s0_bad, first_addr4;
  int pbi4_q[$], pbi8_q[$], addr4_q[$];

  // Observation log sampled mid-cycle.
  always @(negedge clk) begin
    if (w_req4 === 1'b1) begin
      if (wreq4_n == 0) first_addr4 = int'(w_addr4);
      wreq4_n++;
      addr4_q.push_back(int'(w_addr4));
      if (int'(w_addr4) < 5) addr_i0_n++;
    end
    if (pb_en4 === 1'b1) begin pben4_n++; pbi4_q.push_back(int'(pb_I4)); end
    if (done4 === 1'b1) done4_n++;
    if (busy4 === 1'b1) begin
      busy4_n++;
      if (state4[0] !== 1'b1) s0_bad++;
    end
    if (w_req8 === 1'b1) wreq8_n++;
    if (pb_en8 === 1'b1) begin pben8_n++; pbi8_q.push_back(int'(pb_I8)); end
    if (done8 === 1'b1) done8_n++;
  end

  task automatic clear_log();
    wreq4_n = 0; pben4_n = 0; done4_n = 0; busy4_n = 0;
    wreq8_n = 0; pben8_n = 0; done8_n = 0;
    addr_i0_n = 0; s0_bad = 0; first_addr4 = -1;
    pbi4_q.delete(); pbi8_q.delete(); addr4_q.delete();
  endtask

  task automatic pulse_start(input bit sel8, input int n);
    @(posedge clk);
    #1;
    if (sel8) begin nsw8 = 16'(n); start8 = 1'b1; end
    else begin nsw4 = 16'(n); start4 = 1'b1; end
    @(posedge clk);
    #1 start4 = 1'b0; start8 = 1'b0;
  endtask

  task automatic wait_done(input bit sel8, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((sel8 ? done8 : done4) === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy4, done4, w_req4, pb_en4} !== 4'b0) begin failures++; $display("FAIL reset_ctl4: got %b want 0000", {busy4, done4, w_req4, pb_en4}); end
    checks++; if (pb_I4 !== 8'sd0 || state4 !== 4'b0 || scnt4 !== 16'd0) begin failures++; $display("FAIL reset_dat4: pb_I=%0d state=%b sweep_cnt=%0d want 0", pb_I4, state4, scnt4); end
    checks++; if ({busy8, done8, w_req8, pb_en8} !== 4'b0) begin failures++; $display("FAIL reset_ctl8: got %b want 0000", {busy8, done8, w_req8, pb_en8}); end
    checks++; if (pb_I8 !== 8'sd0 || state8 !== 8'b0 || scnt8 !== 16'd0) begin failures++; $display("FAIL reset_dat8: pb_I=%0d state=%b sweep_cnt=%0d want 0", pb_I8, state8, scnt8); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_sweep();
    bit ok;
    int bad;
    clear_log(); mode = 0; lat_fixed = 1;
    pulse_start(1'b0, 1);
    @(negedge clk);
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy4); end
    wait_done(1'b0, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: done got 0 want 1 within 400 cycles"); end
    checks++; if (done4_n !== 1) begin failures++; $display("FAIL single_done_cnt: got %0d want 1", done4_n); end
    checks++; if (scnt4 !== 16'd1) begin failures++; $display("FAIL single_sweep_cnt: got %0d want 1", scnt4); end
    checks++; if (state4 !== 4'b1111) begin failures++; $display("FAIL single_state: got %b want 1111", state4); end
    checks++; if (wreq4_n !== 16) begin failures++; $display("FAIL single_wreq: got %0d want 16", wreq4_n); end
    checks++; if (pben4_n !== 4) begin failures++; $display("FAIL single_pben: got %0d want 4", pben4_n); end
    bad = 0;
    foreach (pbi4_q[k]) if (pbi4_q[k] != 100) bad++;
    checks++; if (bad != 0 || pbi4_q.size() != 4) begin failures++; $display("FAIL single_pb_I: %0d of %0d values differ from 100", bad, pbi4_q.size()); end
    bad = 0;
    foreach (addr4_q[k]) if (k < 16 && addr4_q[k] != exp_addr4[k]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_addr: %0d addresses wrong, first got %0d want 1", bad, first_addr4); end
  endtask

  task automatic test_zero_sweeps();
    clear_log();
    pulse_start(1'b0, 0);
    @(negedge clk);
    checks++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin failures++; $display("FAIL zero_done: done=%b busy=%b want done=1 busy=0", done4, busy4); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (wreq4_n !== 0 || pben4_n !== 0) begin failures++; $display("FAIL zero_activity: w_req=%0d pb_enable=%0d want 0 0", wreq4_n, pben4_n); end
    checks++; if (scnt4 !== 16'd0 || done4_n !== 1) begin failures++; $display("FAIL zero_cnt: sweep_cnt=%0d dones=%0d want 0 1", scnt4, done4_n); end
    checks++; if (state4 !== 4'b1111) begin failures++; $display("FAIL zero_state_hold: got %b want 1111", state4); end
  endtask

  task automatic test_saturation();
    bit ok;
    int bad;
    clear_log(); mode = 0; lat_fixed = 1;
    pulse_start(1'b1, 1);
    wait_done(1'b1, 1000, ok);
    checks++; if (!ok || state8 !== 8'hFF) begin failures++; $display("FAIL sat_preset: ok=%b state=%h want 1 ff", ok, state8); end
    clear_log(); mode = 1;
    pulse_start(1'b1, 1);
    wait_done(1'b1, 1000, ok);
    bad = 0;
    foreach (pbi8_q[k]) if (pbi8_q[k] != 127) bad++;
    checks++; if (!ok || bad != 0 || pben8_n != 8) begin failures++; $display("FAIL sat_pos: ok=%b evals=%0d bad=%0d want 1 8 0", ok, pben8_n, bad); end
    checks++; if (state8 !== 8'hFF || wreq8_n !== 64) begin failures++; $display("FAIL sat_pos_state: state=%h w_req=%0d want ff 64", state8, wreq8_n); end
    clear_log(); mode = 2;
    pulse_start(1'b1, 1);
    wait_done(1'b1, 1000, ok);
    bad = 0;
    foreach (pbi8_q[k]) if (k < 8 && pbi8_q[k] != exp_neg8[k]) bad++;
    checks++; if (!ok || bad != 0 || pbi8_q.size() != 8) begin failures++; $display("FAIL sat_neg: ok=%b evals=%0d bad=%0d want 1 8 0", ok, pbi8_q.size(), bad); end
    checks++; if (state8 !== 8'hE0 || scnt8 !== 16'd1) begin failures++; $display("FAIL sat_neg_state: state=%h sweep_cnt=%0d want e0 1", state8, scnt8); end
    mode = 0;
  endtask

  task automatic test_latency_busy_start();
    bit ok;
    int bad;
    clear_log(); mode = 0; lat_fixed = 0; lat_seq = 0;
    pulse_start(1'b0, 2);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin ok = 1'b1; break; end
      nsw4   = 16'd5;
      start4 = (c == 5 || c == 40 || c == 77);
    end
    start4 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL lat_timeout: done got 0 want 1 within 3000 cycles"); end
    checks++; if (done4_n !== 1 || busy4 !== 1'b0) begin failures++; $display("FAIL lat_single_done: dones=%0d busy=%b want 1 0", done4_n, busy4); end
    checks++; if (scnt4 !== 16'd2 || state4 !== 4'b1111) begin failures++; $display("FAIL lat_result: sweep_cnt=%0d state=%b want 2 1111", scnt4, state4); end
    checks++; if (wreq4_n !== 32 || pben4_n !== 8) begin failures++; $display("FAIL lat_counts: w_req=%0d pb_enable=%0d want 32 8", wreq4_n, pben4_n); end
    bad = 0;
    foreach (addr4_q[k]) if (addr4_q[k] != exp_addr4[k % 16]) bad++;
    foreach (pbi4_q[k]) if (pbi4_q[k] != 100) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL lat_trace: %0d addresses/pb_I values differ, want 0", bad); end
    lat_fixed = 1;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    clear_log(); mode = 0; lat_fixed = 7;
    pulse_start(1'b0, 3);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (scnt4 == 16'd1 && busy4 === 1'b1 && w_req4 === 1'b0 && pb_en4 === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_reach: WAIT of sweep 2 got 0 want 1 within 2000 cycles"); end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy4, done4, w_req4, pb_en4} !== 4'b0 || pb_I4 !== 8'sd0) begin failures++; $display("FAIL rst_mid_ctl: ctl=%b pb_I=%0d want 0000 0", {busy4, done4, w_req4, pb_en4}, pb_I4); end
    checks++; if (state4 !== 4'b0 || scnt4 !== 16'd0) begin failures++; $display("FAIL rst_mid_dat: state=%b sweep_cnt=%0d want 0 0", state4, scnt4); end
    clear_log();
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (wreq4_n !== 0 || busy4_n !== 0 || state4 !== 4'b0) begin failures++; $display("FAIL rst_mid_late_valid: w_req=%0d busy=%0d state=%b want 0 0 0000", wreq4_n, busy4_n, state4); end
    clear_log(); lat_fixed = 1;
    pulse_start(1'b0, 1);
    wait_done(1'b0, 400, ok);
    checks++; if (!ok || done4_n !== 1 || scnt4 !== 16'd1) begin failures++; $display("FAIL rst_mid_rerun: ok=%b dones=%0d sweep_cnt=%0d want 1 1 1", ok, done4_n, scnt4); end
    checks++; if (state4 !== 4'b1111 || wreq4_n !== 16 || first_addr4 !== 1) begin failures++; $display("FAIL rst_mid_rerun_res: state=%b w_req=%0d first_addr=%0d want 1111 16 1", state4, wreq4_n, first_addr4); end
  endtask

`ifdef PBIT_SCHED_CLAMP_EN
  task automatic test_clamp();
    bit ok;
    int bad;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    clamp_mask4 = 4'b0001; clamp_val4 = 4'b0001;
    clear_log(); mode = 0; lat_fixed = 1;
    pulse_start(1'b0, 2);
    @(negedge clk);
    checks++; if (state4[0] !== 1'b1) begin failures++; $display("FAIL clamp_force: state[0]=%b want 1", state4[0]); end
    wait_done(1'b0, 600, ok);
    checks++; if (!ok || addr_i0_n !== 0 || s0_bad !== 0) begin failures++; $display("FAIL clamp_skip: ok=%b i0_addrs=%0d state0_drops=%0d want 1 0 0", ok, addr_i0_n, s0_bad); end
    checks++; if (pben4_n !== 6 || wreq4_n !== 24 || first_addr4 !== 5) begin failures++; $display("FAIL clamp_counts: evals=%0d w_req=%0d first_addr=%0d want 6 24 5", pben4_n, wreq4_n, first_addr4); end
    bad = 0;
    foreach (pbi4_q[k]) if (pbi4_q[k] != 100) bad++;
    checks++; if (bad != 0 || state4 !== 4'b1111 || scnt4 !== 16'd2) begin failures++; $display("FAIL clamp_result: bad_pb_I=%0d state=%b sweep_cnt=%0d want 0 1111 2", bad, state4, scnt4); end
    clamp_mask4 = 4'b0; clamp_val4 = 4'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    nsw4 = 16'd0; nsw8 = 16'd0;
`ifdef PBIT_SCHED_CLAMP_EN
    clamp_mask4 = '0; clamp_val4 = '0; clamp_mask8 = '0; clamp_val8 = '0;
`endif
    clear_log();
    test_reset();
    test_single_sweep();
    test_zero_sweeps();
    test_saturation();
    test_latency_busy_start();
    test_reset_mid_run();
`ifdef PBIT_SCHED_CLAMP_EN
    test_clamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
